// File: rtl/mlblock_seq_ctrl_pkg.sv
// mlblock_ctrl_pkg: sequencer state encoding and shared counter sizing.
package mlblock_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CFG_SHIFT,
        B_LOAD,
        STREAM,
        DRAIN,
        DONE
    } state_e;

    // One down-counter must cover both the chain length and the A-stream length.
    function automatic int cnt_width(input int chain_len, input int k_w);
        return ($clog2(chain_len + 1) > k_w) ? $clog2(chain_len + 1) : k_w;
    endfunction

endpackage

// File: rtl/mlblock_seq_ctrl_if.sv
// mlblock_seq_ctrl_if: scheduler-side config and start handshakes of the tile sequencer.
interface mlblock_seq_ctrl_if #(
    parameter int CHAIN_LEN = 32,
    parameter int K_W       = 16
);
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [CHAIN_LEN-1:0] cfg_data;
    logic                 start;
    logic [K_W-1:0]       k_len;
    logic                 hp_mode;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output cfg_valid, cfg_data, start, k_len, hp_mode,
        input  cfg_ready, busy, done, err
    );

    modport slave (
        input  cfg_valid, cfg_data, start, k_len, hp_mode,
        output cfg_ready, busy, done, err
    );
endinterface

// File: rtl/mlblock_seq_ctrl_cfg_shifter.sv
// mlblock_cfg_shifter: parallel-in serial-out config image, MSB first; empties to zero.
module mlblock_cfg_shifter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [N-1:0] data_i,
    output logic         bit_o
);
    logic [N-1:0] sr_q;

    always_ff @(posedge clk) begin
        if (reset)        sr_q <= '0;
        else if (load_i)  sr_q <= data_i;
        else if (shift_i) sr_q <= sr_q << 1;
    end

    assign bit_o = sr_q[N-1];
endmodule

// File: rtl/mlblock_seq_ctrl.sv
// mlblock_seq_ctrl: loads the MLBlock config chain, then runs B preload, A stream,
// drain and a done pulse; every MLBlock pin comes straight from a flop.
module mlblock_seq_ctrl
    import mlblock_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = 32,
    parameter int B_D       = 4,
    parameter int K_W       = 16,
    parameter int DRAIN_CYC = 8
) (
    input  logic              clk,
    input  logic              reset,
    mlblock_seq_ctrl_if.slave sch,
    output logic              config_en_o,
    output logic              config_out_o,
    output logic              a_en_o,
    output logic              b_en_o,
    output logic              acc_en_o,
    output logic              hp_en_o
);
    localparam int CW = cnt_width(CHAIN_LEN, K_W);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [K_W-1:0] k_q, k_d;
    logic           hp_q, hp_d, loaded_q, loaded_d, load, err_d;
    logic           cfg_ready_q, busy_q, cfg_en_q, b_en_q, stream_q, hp_en_q, done_q, err_q;
    state_e         post_stream;
    logic [CW-1:0]  post_stream_cnt;

    assign post_stream     = (DRAIN_CYC != 0) ? DRAIN : DONE;
    assign post_stream_cnt = CW'(DRAIN_CYC - 1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        hp_d     = hp_q;
        loaded_d = loaded_q;
        load     = 1'b0;
        err_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sch.cfg_valid) begin
                    state_d = CFG_SHIFT;
                    cnt_d   = CW'(CHAIN_LEN - 1);
                    load    = 1'b1;
                end else if (sch.start && loaded_q) begin
                    state_d = B_LOAD;
                    cnt_d   = CW'(B_D - 1);
                    k_d     = sch.k_len;
                    hp_d    = sch.hp_mode;
                end else begin
                    err_d = sch.start;
                end
            end
            CFG_SHIFT: begin
                state_d  = (cnt_q == '0) ? IDLE : CFG_SHIFT;
                loaded_d = loaded_q | (cnt_q == '0);
                cnt_d    = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
            end
            B_LOAD: begin
                state_d = (cnt_q != '0) ? B_LOAD : (k_q != '0) ? STREAM : post_stream;
                cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : (k_q != '0) ? CW'(k_q) - CW'(1) : post_stream_cnt;
            end
            STREAM: begin
                state_d = (cnt_q != '0) ? STREAM : post_stream;
                cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : post_stream_cnt;
            end
            DRAIN: begin
                state_d = (cnt_q != '0) ? DRAIN : DONE;
                cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and flopped, so pins change with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            k_q         <= '0;
            hp_q        <= 1'b0;
            loaded_q    <= 1'b0;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            cfg_en_q    <= 1'b0;
            b_en_q      <= 1'b0;
            stream_q    <= 1'b0;
            hp_en_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            hp_q        <= hp_d;
            loaded_q    <= loaded_d;
            cfg_ready_q <= state_d == IDLE;
            busy_q      <= state_d != IDLE;
            cfg_en_q    <= state_d == CFG_SHIFT;
            b_en_q      <= state_d == B_LOAD;
            stream_q    <= state_d == STREAM;
            hp_en_q     <= hp_d && (state_d inside {B_LOAD, STREAM, DRAIN});
            done_q      <= state_d == DONE;
            err_q       <= err_d;
        end
    end

    mlblock_cfg_shifter #(.N(CHAIN_LEN)) u_shifter (
        .clk     (clk),
        .reset   (reset),
        .load_i  (load),
        .shift_i (state_q == CFG_SHIFT),
        .data_i  (sch.cfg_data),
        .bit_o   (config_out_o)
    );

    assign sch.cfg_ready = cfg_ready_q;
    assign sch.busy      = busy_q;
    assign sch.done      = done_q;
    assign sch.err       = err_q;
    assign config_en_o   = cfg_en_q;
    assign b_en_o        = b_en_q;
    assign a_en_o        = stream_q;
    assign acc_en_o      = stream_q;
    assign hp_en_o       = hp_en_q;
endmodule

// File: tb/tb_mlblock_seq_ctrl.sv
// tb_mlblock_seq_ctrl: directed sequence with per-cycle output traces compared to hand-built masks.
module tb_mlblock_seq_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic config_en, config_out, a_en, b_en, acc_en, hp_en;
    logic [31:0] chain = '0;
    logic [31:0] ser;
    logic [63:0] v_cfgen, v_rdy, v_busy, v_b, v_a, v_acc, v_hp, v_done, v_err, v_ovl;
    int n_cmp = 0;
    int n_bad = 0;

    mlblock_seq_ctrl_if #(.CHAIN_LEN(32), .K_W(16)) sif ();

    mlblock_seq_ctrl #(.CHAIN_LEN(32), .B_D(4), .K_W(16), .DRAIN_CYC(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .sch          (sif),
        .config_en_o  (config_en),
        .config_out_o (config_out),
        .a_en_o       (a_en),
        .b_en_o       (b_en),
        .acc_en_o     (acc_en),
        .hp_en_o      (hp_en)
    );

    always #5 clk = ~clk;

    // MLBlock-side chain: position 0 sits next to config_in
    always @(posedge clk) if (config_en) chain <= {chain[30:0], config_out};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        {v_cfgen, v_rdy, v_busy, v_b, v_a, v_acc, v_hp, v_done, v_err, v_ovl} = '0;
        ser = '0;
    endtask

    task automatic tick(input int c);
        @(posedge clk);
        #1;
        v_cfgen[c] = config_en;
        v_rdy[c]   = sif.cfg_ready;
        v_busy[c]  = sif.busy;
        v_b[c]     = b_en;
        v_a[c]     = a_en;
        v_acc[c]   = acc_en;
        v_hp[c]    = hp_en;
        v_done[c]  = sif.done;
        v_err[c]   = sif.err;
        v_ovl[c]   = config_en & (a_en | b_en | acc_en);
        if (config_en) ser = {ser[30:0], config_out};
    endtask

    initial begin
        sif.cfg_valid = 1'b0;
        sif.cfg_data  = '0;
        sif.start     = 1'b0;
        sif.k_len     = '0;
        sif.hp_mode   = 1'b0;
        clr();
        tick(0);
        tick(0);
        chk("rst_ready", 64'(sif.cfg_ready), 64'd1);
        chk("rst_busy", 64'(sif.busy), 64'd0);
        chk("rst_done_err", {sif.done, sif.err}, 64'd0);
        chk("rst_pins", {config_en, config_out, a_en, b_en, acc_en, hp_en}, 64'd0);
        reset = 1'b0;
        tick(0);

        // start with no configuration loaded
        clr();
        sif.start = 1'b1;
        sif.k_len = 16'd5;
        for (int c = 1; c <= 4; c++) begin
            tick(c);
            sif.start = 1'b0;
        end
        chk("noload_err", v_err, 64'h2);
        chk("noload_busy", v_busy, 64'h0);
        chk("noload_ready", v_rdy, 64'h1E);
        chk("noload_en", v_b | v_a | v_acc | v_cfgen | v_hp, 64'h0);

        // config with a simultaneous start: config wins, start is dropped
        clr();
        sif.cfg_valid = 1'b1;
        sif.cfg_data  = 32'hA5C3_0F01;
        sif.start     = 1'b1;
        for (int c = 1; c <= 39; c++) begin
            tick(c);
            sif.cfg_valid = 1'b0;
            sif.start     = 1'b0;
            sif.cfg_data  = 32'hFFFF_FFFF;
        end
        chk("cfg_en", v_cfgen, 64'h0000_0001_FFFF_FFFE);
        chk("cfg_busy", v_busy, 64'h0000_0001_FFFF_FFFE);
        chk("cfg_ready", v_rdy, 64'h0000_00FE_0000_0000);
        chk("cfg_serial", 64'(ser), 64'hA5C3_0F01);
        chk("cfg_chain", 64'(chain), 64'hA5C3_0F01);
        chk("cfg_start_dropped", v_b | v_a | v_err, 64'h0);
        chk("cfg_out_idle", 64'(config_out), 64'd0);

        // full pass k_len=5 hp=1; input changes, start and cfg_valid mid-pass are ignored
        clr();
        sif.start   = 1'b1;
        sif.k_len   = 16'd5;
        sif.hp_mode = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick(c);
            sif.start     = (c == 6);
            sif.cfg_valid = (c == 9);
            if (c == 2) begin
                sif.k_len   = 16'd2;
                sif.hp_mode = 1'b0;
            end
        end
        chk("p5_b", v_b, 64'h1E);
        chk("p5_a", v_a, 64'h3E0);
        chk("p5_acc", v_acc, 64'h3E0);
        chk("p5_hp", v_hp, 64'h3FFFE);
        chk("p5_done", v_done, 64'h40000);
        chk("p5_busy", v_busy, 64'h7FFFE);
        chk("p5_ready", v_rdy, 64'h1F80000);
        chk("p5_cfg_err", v_cfgen | v_err, 64'h0);
        chk("p5_overlap", v_ovl, 64'h0);

        // k_len=0 skips STREAM; configuration survives the previous pass
        clr();
        sif.start   = 1'b1;
        sif.k_len   = 16'd0;
        sif.hp_mode = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick(c);
            sif.start = 1'b0;
        end
        chk("p0_b", v_b, 64'h1E);
        chk("p0_a_acc", v_a | v_acc, 64'h0);
        chk("p0_done", v_done, 64'h2000);
        chk("p0_busy", v_busy, 64'h3FFE);
        chk("p0_hp", v_hp, 64'h0);
        chk("p0_ready", v_rdy, 64'h1C000);

        // reset during the third STREAM cycle
        clr();
        sif.start   = 1'b1;
        sif.k_len   = 16'd5;
        sif.hp_mode = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick(c);
            sif.start = 1'b0;
        end
        chk("rs_in_stream", {a_en, acc_en, hp_en}, 64'h7);
        reset = 1'b1;
        tick(8);
        reset = 1'b0;
        chk("rs_pins", {config_en, a_en, b_en, acc_en, hp_en}, 64'h0);
        chk("rs_ready_busy", {sif.cfg_ready, sif.busy}, 64'h2);
        clr();
        sif.start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick(c);
            sif.start = 1'b0;
        end
        chk("rs_err", v_err, 64'h2);
        chk("rs_no_pass", v_busy | v_b, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
